fb_write_sched: RTL



---
 rtl/fb_write_sched.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fb_write_sched.sv
// Write-side scheduler for the VGA frame buffer: shares one registered write
// port between a raster-order pixel stream and a random-access debug poke port.
module fb_write_sched #(
  parameter int H_PIX      = 256,
  parameter int V_PIX      = 240,
  parameter int COL_W      = 6,
  parameter int STARVE_MAX = 16
) (
  input  logic             ppu_clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [COL_W-1:0] pix_col,
  output logic             pix_ready,
  input  logic             dbg_req,
  input  logic [7:0]       dbg_x,
  input  logic [7:0]       dbg_y,
  input  logic [COL_W-1:0] dbg_col,
  output logic             dbg_ack,
  output logic [7:0]       fb_x,
  output logic [7:0]       fb_y,
  output logic [COL_W-1:0] fb_DI,
  output logic             fb_we,
  output logic             busy,
  output logic             frame_done,
  output logic             restart_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [7:0]    X_LAST     = 8'(H_PIX - 1);
  localparam logic [7:0]    Y_LAST     = 8'(V_PIX - 1);
  localparam logic [8:0]    X_LIM      = 9'(H_PIX);
  localparam logic [8:0]    Y_LIM      = 9'(V_PIX);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [7:0]       rx_q, rx_d;
  logic [7:0]       ry_q, ry_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             ack_prev_q, ack_prev_d;
  logic             err_q, err_d;
  logic             fb_we_q, fb_we_d;
  logic [7:0]       fb_x_q, fb_x_d;
  logic [7:0]       fb_y_q, fb_y_d;
  logic [COL_W-1:0] fb_di_q, fb_di_d;
  logic             done_q, done_d;

  logic force_dbg;
  logic stream_grant;
  logic dbg_grant;
  logic dbg_in_range;
  logic last_accept;

  // Arbitration depends only on control inputs and state, never on data.
  always_comb begin
    force_dbg    = dbg_req && (starve_q == STARVE_TOP);
    stream_grant = !force_dbg && (state_q == STREAM) && pix_valid;
    dbg_grant    = force_dbg || (!stream_grant && dbg_req && !ack_prev_q);
    dbg_in_range = ({1'b0, dbg_x} < X_LIM) && ({1'b0, dbg_y} < Y_LIM);
    last_accept  = stream_grant && (rx_q == X_LAST) && (ry_q == Y_LAST);
  end

  assign pix_ready = (state_q == STREAM) && !force_dbg;
  assign dbg_ack   = dbg_grant;

  always_comb begin
    state_d = state_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = STREAM;
          rx_d    = 8'd0;
          ry_d    = 8'd0;
        end
      end
      STREAM: begin
        if (stream_grant) begin
          if (rx_q == X_LAST) begin
            rx_d = 8'd0;
            ry_d = ry_q + 8'd1;
          end else begin
            rx_d = rx_q + 8'd1;
          end
        end
        if (last_accept) begin
          state_d = IDLE;
          ry_d    = 8'd0;
        end
        // A restart on the final pixel is a clean back-to-back frame, not an error.
        if (frame_start) begin
          state_d = STREAM;
          rx_d    = 8'd0;
          ry_d    = 8'd0;
          if (!last_accept) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!dbg_req || dbg_grant) begin
      starve_d = '0;
    end else if (starve_q != STARVE_TOP) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_comb begin
    fb_we_d    = 1'b0;
    fb_x_d     = fb_x_q;
    fb_y_d     = fb_y_q;
    fb_di_d    = fb_di_q;
    done_d     = last_accept;
    ack_prev_d = dbg_grant;
    if (stream_grant) begin
      fb_we_d = 1'b1;
      fb_x_d  = rx_q;
      fb_y_d  = ry_q;
      fb_di_d = pix_col;
    end else if (dbg_grant && dbg_in_range) begin
      fb_we_d = 1'b1;
      fb_x_d  = dbg_x;
      fb_y_d  = dbg_y;
      fb_di_d = dbg_col;
    end
  end

  always_ff @(posedge ppu_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_q       <= 8'd0;
      ry_q       <= 8'd0;
      starve_q   <= '0;
      ack_prev_q <= 1'b0;
      err_q      <= 1'b0;
      fb_we_q    <= 1'b0;
      fb_x_q     <= 8'd0;
      fb_y_q     <= 8'd0;
      fb_di_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      starve_q   <= starve_d;
      ack_prev_q <= ack_prev_d;
      err_q      <= err_d;
      fb_we_q    <= fb_we_d;
      fb_x_q     <= fb_x_d;
      fb_y_q     <= fb_y_d;
      fb_di_q    <= fb_di_d;
      done_q     <= done_d;
    end
  end

  assign fb_we       = fb_we_q;
  assign fb_x        = fb_x_q;
  assign fb_y        = fb_y_q;
  assign fb_DI       = fb_di_q;
  assign frame_done  = done_q;
  assign restart_err = err_q;
  assign busy        = (state_q == STREAM);

endmodule
